ku040_rst_seq: RTL and testbench

//  Reset sequencer downstream of ku040_clk. Takes async DCM_LOCKED, requires lock
//  to be stable, then releases CORE_RST_X, then USER_RST_X after a stagger.
//  Re-asserts both on lock loss and counts loss events. Feeds all fabric reset trees.

---
 rtl/ku040_rst_seq_pkg.sv | 21 ++
 rtl/ku040_sync.sv | 24 ++
 rtl/ku040_rst_seq.sv | 195 +++++++++++++++++++
 tb/tb_ku040_rst_seq.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ku040_rst_seq_pkg.sv
// Shared definitions for the ku040 reset sequencer: FSM state encodings and a
// counter-width helper used to size the sequencing counters.
package ku040_rst_seq_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        REL_CORE  = 3'd2,
        RUN       = 3'd3,
        RERST     = 3'd4
    } rst_state_e;

    // Bits needed to hold the values 0..n-1, never less than one.
    function automatic int clog2_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/ku040_sync.sv
// Multi-flop synchronizer bringing a single asynchronous level into the CLK
// domain; cleared asynchronously so the sequencer restarts from "unlocked".
module ku040_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST_X,
    input  logic D_ASYNC,
    output logic Q_SYNC
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], D_ASYNC};
        end
    end

    assign Q_SYNC = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ku040_rst_seq.sv
// Reset sequencer: waits for a stable MMCM lock, releases CORE_RST_X and then
// USER_RST_X, and drops both on lock loss. Optional macro LOCK_TIMEOUT_EN adds
// an MMCM re-reset request when lock never settles.
module ku040_rst_seq #(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 1024,
    parameter int CORE_TO_USER   = 256,
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int RERST_CYCLES   = 256
) (
    input  logic             CLK,
    input  logic             RST_X,
    input  logic             DCM_LOCKED,
    output logic             CORE_RST_X,
    output logic             USER_RST_X,
    output logic             READY,
    output logic [CNT_W-1:0] LOCK_LOSS_CNT,
    output logic             DCM_RST_REQ
);
    import ku040_rst_seq_pkg::*;

    if (SYNC_STAGES < 2 || STABLE_CYCLES < 1 || CORE_TO_USER < 1 || CNT_W < 1 ||
        TIMEOUT_CYCLES < 1 || RERST_CYCLES < 1) begin : g_param_err
        $error("ku040_rst_seq: illegal parameter value");
    end

    // One counter serves the stability window, the core-to-user stagger and the
    // re-reset pulse, since those phases never overlap.
`ifdef LOCK_TIMEOUT_EN
    localparam int SEQ_MAX0 = (STABLE_CYCLES > CORE_TO_USER) ? STABLE_CYCLES : CORE_TO_USER;
    localparam int SEQ_MAX  = (SEQ_MAX0 > RERST_CYCLES) ? SEQ_MAX0 : RERST_CYCLES;
`else
    localparam int SEQ_MAX  = (STABLE_CYCLES > CORE_TO_USER) ? STABLE_CYCLES : CORE_TO_USER;
`endif
    localparam int SEQ_W = clog2_w(SEQ_MAX);
    localparam logic [SEQ_W-1:0] STAB_LAST = SEQ_W'(STABLE_CYCLES - 1);
    localparam logic [SEQ_W-1:0] USER_LAST = SEQ_W'(CORE_TO_USER - 1);

    rst_state_e       state_q, state_d;
    logic [SEQ_W-1:0] seq_cnt_q, seq_cnt_d;
    logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;
    logic             core_q, core_d;
    logic             user_q, user_d;
    logic             ready_q;
    logic             lock_s;

`ifdef LOCK_TIMEOUT_EN
    localparam int TO_W = clog2_w(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SEQ_W-1:0] RERST_LAST = SEQ_W'(RERST_CYCLES - 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            req_q, req_d;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    ku040_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .CLK     (CLK),
        .RST_X   (RST_X),
        .D_ASYNC (DCM_LOCKED),
        .Q_SYNC  (lock_s)
    );

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q    <= WAIT_LOCK;
            seq_cnt_q  <= '0;
            loss_cnt_q <= '0;
            core_q     <= 1'b0;
            user_q     <= 1'b0;
            ready_q    <= 1'b0;
`ifdef LOCK_TIMEOUT_EN
            to_cnt_q   <= '0;
            req_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            seq_cnt_q  <= seq_cnt_d;
            loss_cnt_q <= loss_cnt_d;
            core_q     <= core_d;
            user_q     <= user_d;
            ready_q    <= user_d;
`ifdef LOCK_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
            req_q      <= req_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        seq_cnt_d  = seq_cnt_q;
        loss_cnt_d = loss_cnt_q;
`ifdef LOCK_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
`endif
        case (state_q)
            WAIT_LOCK: begin
                seq_cnt_d = '0;
                if (lock_s) begin
                    if (STABLE_CYCLES == 1) begin
                        state_d = REL_CORE;
                    end else begin
                        state_d   = STABLE;
                        seq_cnt_d = SEQ_W'(1);
                    end
                end
            end
            STABLE: begin
                // A drop here is a failed qualification, not a loss event.
                if (!lock_s) begin
                    state_d   = WAIT_LOCK;
                    seq_cnt_d = '0;
                end else if (seq_cnt_q == STAB_LAST) begin
                    state_d   = REL_CORE;
                    seq_cnt_d = '0;
                end else begin
                    seq_cnt_d = seq_cnt_q + 1'b1;
                end
            end
            REL_CORE: begin
                if (!lock_s) begin
                    state_d    = WAIT_LOCK;
                    seq_cnt_d  = '0;
                    loss_cnt_d = sat_inc(loss_cnt_q);
                end else if (seq_cnt_q == USER_LAST) begin
                    state_d   = RUN;
                    seq_cnt_d = '0;
                end else begin
                    seq_cnt_d = seq_cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d    = WAIT_LOCK;
                    seq_cnt_d  = '0;
                    loss_cnt_d = sat_inc(loss_cnt_q);
                end
            end
`ifdef LOCK_TIMEOUT_EN
            RERST: begin
                if (seq_cnt_q == RERST_LAST) begin
                    state_d   = WAIT_LOCK;
                    seq_cnt_d = '0;
                end else begin
                    seq_cnt_d = seq_cnt_q + 1'b1;
                end
            end
`endif
            default: begin
                state_d   = WAIT_LOCK;
                seq_cnt_d = '0;
            end
        endcase
`ifdef LOCK_TIMEOUT_EN
        // Timeout spans STABLE->WAIT_LOCK bounces so a chattering lock still expires.
        if (state_q == WAIT_LOCK || state_q == STABLE) begin
            if (state_d == REL_CORE) begin
                to_cnt_d = '0;
            end else if (to_cnt_q == TO_LAST) begin
                state_d   = RERST;
                seq_cnt_d = '0;
                to_cnt_d  = '0;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
`endif
    end

    // Outputs are decoded from the next state and registered, so they never glitch.
    always_comb begin
        core_d = (state_d == REL_CORE) || (state_d == RUN);
        user_d = (state_d == RUN);
`ifdef LOCK_TIMEOUT_EN
        req_d  = (state_d == RERST);
`endif
    end

    assign CORE_RST_X    = core_q;
    assign USER_RST_X    = user_q;
    assign READY         = ready_q;
    assign LOCK_LOSS_CNT = loss_cnt_q;
`ifdef LOCK_TIMEOUT_EN
    assign DCM_RST_REQ   = req_q;
`else
    assign DCM_RST_REQ   = 1'b0;
`endif

endmodule

// File: tb/tb_ku040_rst_seq.sv
// Bench for ku040_rst_seq: directed scenarios plus randomized lock traffic,
// compared cycle by cycle against a streak-counting reference model.
module tb_ku040_rst_seq;

    localparam int SYNC     = 2;
    localparam int STAB     = 16;
    localparam int C2U      = 8;
    localparam int CW       = 2;
    localparam int TMO      = 100;
    localparam int RR       = 10;
    localparam int LOSS_MAX = (1 << CW) - 1;

    logic          CLK = 1'b0;
    logic          RST_X = 1'b0;
    logic          DCM_LOCKED = 1'b0;
    logic          CORE_RST_X;
    logic          USER_RST_X;
    logic          READY;
    logic [CW-1:0] LOCK_LOSS_CNT;
    logic          DCM_RST_REQ;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    ku040_rst_seq #(
        .SYNC_STAGES    (SYNC),
        .STABLE_CYCLES  (STAB),
        .CORE_TO_USER   (C2U),
        .CNT_W          (CW),
        .TIMEOUT_CYCLES (TMO),
        .RERST_CYCLES   (RR)
    ) dut (
        .CLK           (CLK),
        .RST_X         (RST_X),
        .DCM_LOCKED    (DCM_LOCKED),
        .CORE_RST_X    (CORE_RST_X),
        .USER_RST_X    (USER_RST_X),
        .READY         (READY),
        .LOCK_LOSS_CNT (LOCK_LOSS_CNT),
        .DCM_RST_REQ   (DCM_RST_REQ)
    );

    always #2 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Reference model: the FSM sees DCM_LOCKED delayed by SYNC edges; CORE is
    // released after STAB consecutive locked samples, USER C2U edges later.
    bit q_lock[$];
    int e, streak, rel_edge, m_loss, to_cnt, rr_left;
    bit m_core, m_user, m_req;

    always @(posedge CLK or negedge RST_X) begin
        bit s;
        bit pre;
        if (!RST_X) begin
            q_lock.delete();
            e = 0; streak = 0; rel_edge = 0; m_loss = 0; to_cnt = 0; rr_left = 0;
            m_core = 1'b0; m_user = 1'b0; m_req = 1'b0;
        end else begin
            e++;
            s = (q_lock.size() == SYNC) ? q_lock.pop_front() : 1'b0;
            q_lock.push_back(DCM_LOCKED);
            pre = m_core;
            if (rr_left > 0) begin
                rr_left--;
                if (rr_left == 0) m_req = 1'b0;
            end else begin
                if (!s) begin
                    if (m_core && m_loss < LOSS_MAX) m_loss++;
                    m_core = 1'b0;
                    m_user = 1'b0;
                    streak = 0;
                end else begin
                    streak++;
                    if (!m_core) begin
                        if (streak == STAB) begin
                            m_core   = 1'b1;
                            rel_edge = e;
                        end
                    end else if (!m_user && (e - rel_edge) == C2U) begin
                        m_user = 1'b1;
                    end
                end
`ifdef LOCK_TIMEOUT_EN
                if (!pre) begin
                    if (m_core) begin
                        to_cnt = 0;
                    end else if (to_cnt == TMO - 1) begin
                        to_cnt  = 0;
                        streak  = 0;
                        m_req   = 1'b1;
                        rr_left = RR;
                    end else begin
                        to_cnt++;
                    end
                end
`endif
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en)
            chk("outs", {CORE_RST_X, USER_RST_X, READY, LOCK_LOSS_CNT, DCM_RST_REQ},
                {m_core, m_user, m_user, CW'(m_loss), m_req});
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    function automatic logic pick(input int sel);
        case (sel)
            0:       return CORE_RST_X;
            1:       return USER_RST_X;
            default: return DCM_RST_REQ;
        endcase
    endfunction

    task automatic wait_out(input string tag, input int sel, input logic val,
                            input int budget, output int at);
        int k;
        k = 0;
        while (pick(sel) !== val && k < budget) begin
            @(negedge CLK);
            k++;
        end
        at = cyc;
        if (pick(sel) !== val) chk(tag, {31'b0, pick(sel)}, {31'b0, val});
    endtask

    initial begin
        int t0, t1, t2;
        int h, l;

        // Power-up
        cycles(5);
        chk("rst_core", CORE_RST_X, 0);
        chk("rst_user", USER_RST_X, 0);
        chk("rst_ready", READY, 0);
        chk("rst_loss", LOCK_LOSS_CNT, 0);
        chk("rst_req", DCM_RST_REQ, 0);
        RST_X  = 1'b1;
        chk_en = 1'b1;
        cycles(5);
        DCM_LOCKED = 1'b1;
        t0 = cyc;
        wait_out("tmo_core_up", 0, 1'b1, 60, t1);
        chk("core_lat", t1 - t0, SYNC + STAB);
        wait_out("tmo_user_up", 1, 1'b1, 30, t2);
        chk("user_lat", t2 - t1, C2U);
        chk("ready_up", READY, 1);
        chk("loss_up", LOCK_LOSS_CNT, 0);

        // Loss in RUN
        cycles(3);
        DCM_LOCKED = 1'b0;
        t0 = cyc;
        wait_out("tmo_core_loss", 0, 1'b0, 10, t1);
        chk("loss_lat", t1 - t0, SYNC + 1);
        chk("loss_user", USER_RST_X, 0);
        chk("loss_ready", READY, 0);
        chk("loss_cnt1", LOCK_LOSS_CNT, 1);

        // Chattering relock: release timed from the final rise
        cycles($urandom_range(2, 5));
        h = $urandom_range(3, 12);
        l = $urandom_range(1, 4);
        DCM_LOCKED = 1'b1;
        cycles(h);
        DCM_LOCKED = 1'b0;
        cycles(l);
        DCM_LOCKED = 1'b1;
        t0 = cyc;
        wait_out("tmo_core_chat", 0, 1'b1, 60, t1);
        chk("chatter_lat", t1 - t0, SYNC + STAB);
        chk("chatter_loss", LOCK_LOSS_CNT, 1);

        // Second loss, then a lock one sample short of the stability window
        cycles(2);
        DCM_LOCKED = 1'b0;
        wait_out("tmo_core_loss2", 0, 1'b0, 10, t1);
        chk("loss_cnt2", LOCK_LOSS_CNT, 2);
        cycles(3);
        DCM_LOCKED = 1'b1;
        cycles(STAB - 1);
        DCM_LOCKED = 1'b0;
        cycles(30);
        chk("near_core", CORE_RST_X, 0);
        chk("near_loss", LOCK_LOSS_CNT, 2);

        // Three more losses (some during the stagger) saturate the counter
        for (int k = 3; k <= 5; k++) begin
            DCM_LOCKED = 1'b1;
            wait_out("tmo_core_sat", 0, 1'b1, 60, t1);
            cycles($urandom_range(0, 12));
            DCM_LOCKED = 1'b0;
            t0 = cyc;
            wait_out("tmo_core_satl", 0, 1'b0, 10, t1);
            chk("sat_lat", t1 - t0, SYNC + 1);
            chk("sat_cnt", LOCK_LOSS_CNT, (k < LOSS_MAX) ? k : LOSS_MAX);
            cycles($urandom_range(1, 4));
        end

        // Asynchronous reset during the core-to-user stagger
        DCM_LOCKED = 1'b1;
        wait_out("tmo_core_ar", 0, 1'b1, 60, t1);
        cycles(3);
        #1 RST_X = 1'b0;
        #1;
        chk("arst_core", CORE_RST_X, 0);
        chk("arst_user", USER_RST_X, 0);
        chk("arst_ready", READY, 0);
        chk("arst_loss", LOCK_LOSS_CNT, 0);
        cycles(3);
        RST_X = 1'b1;
        t0 = cyc;
        wait_out("tmo_core_rel", 0, 1'b1, 60, t1);
        chk("arst_relat", t1 - t0, SYNC + STAB);

        // Random lock traffic with occasional resets
        repeat (70) begin
            DCM_LOCKED = ~DCM_LOCKED;
            cycles(($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(10, 60));
            if ($urandom_range(0, 24) == 0) begin
                #1 RST_X = 1'b0;
                cycles(2);
                RST_X = 1'b1;
            end
        end

`ifdef LOCK_TIMEOUT_EN
        DCM_LOCKED = 1'b0;
        #1 RST_X = 1'b0;
        cycles(2);
        RST_X = 1'b1;
        t0 = cyc;
        wait_out("tmo_req_rise", 2, 1'b1, 150, t1);
        chk("to_rise", t1 - t0, TMO);
        wait_out("tmo_req_fall", 2, 1'b0, 20, t2);
        chk("to_width", t2 - t1, RR);
        wait_out("tmo_req_rise2", 2, 1'b1, 150, t1);
        chk("to_period", t1 - t0, TMO + RR + TMO);
`else
        DCM_LOCKED = 1'b0;
        cycles(250);
        chk("req_tied", DCM_RST_REQ, 0);
`endif

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
